// File: rtl/loop_seq_ctrl.sv
// Two-level rows x cols loop sequencer driving an outer and an inner counter via 2-bit load codes.
// Optional `LOOP_SEQ_ABORT_EN adds an abort input that clears both counters and ends the run.
module loop_seq_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] rows,
    input  logic [WIDTH-1:0] cols,
    input  logic             stall,
`ifdef LOOP_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic [1:0]       row_load,
    output logic [1:0]       col_load,
    output logic [WIDTH-1:0] row_idx,
    output logic [WIDTH-1:0] col_idx,
    output logic             step_valid,
    output logic             last,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] LdHold = 2'd0;
    localparam logic [1:0] LdInc  = 2'd1;
    localparam logic [1:0] LdClr  = 2'd2;

    typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rows_q, rows_d;
    logic [WIDTH-1:0] cols_q, cols_d;
    logic [WIDTH-1:0] rows_m1, cols_m1;
    logic             abort_req;

`ifdef LOOP_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Zero dims never reach RUN, so these never underflow where they are used.
    assign rows_m1 = rows_q - WIDTH'(1);
    assign cols_m1 = cols_q - WIDTH'(1);

    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        row_load   = LdHold;
        col_load   = LdHold;
        step_valid = 1'b0;
        last       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    rows_d  = rows;
                    cols_d  = cols;
                    state_d = (rows == '0 || cols == '0) ? StDone : StClear;
                end
            end
            StClear: begin
                busy     = 1'b1;
                row_load = LdClr;
                col_load = LdClr;
                state_d  = abort_req ? StDone : StRun;
            end
            StRun: begin
                busy = 1'b1;
                if (abort_req) begin
                    row_load = LdClr;
                    col_load = LdClr;
                    state_d  = StDone;
                end else if (!stall) begin
                    step_valid = 1'b1;
                    if (col_idx != cols_m1) begin
                        col_load = LdInc;
                    end else if (row_idx != rows_m1) begin
                        col_load = LdClr;
                        row_load = LdInc;
                    end else begin
                        last     = 1'b1;
                        col_load = LdClr;
                        row_load = LdClr;
                        state_d  = StDone;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            rows_q  <= '0;
            cols_q  <= '0;
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
        end
    end

    // Mirrors follow exactly the codes sent to the external counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_idx <= '0;
            col_idx <= '0;
        end else begin
            case (row_load)
                LdInc:   row_idx <= row_idx + WIDTH'(1);
                LdClr:   row_idx <= '0;
                default: row_idx <= row_idx;
            endcase
            case (col_load)
                LdInc:   col_idx <= col_idx + WIDTH'(1);
                LdClr:   col_idx <= '0;
                default: col_idx <= col_idx;
            endcase
        end
    end

endmodule

// File: doc/loop_seq_ctrl.md
# loop_seq_ctrl

Two-level loop sequencer that drives a pair of `counter` instances (outer/row and inner/col) through a rows × cols traversal of the NMA datapath. It issues each counter's 2-bit `load` code, mirrors the counter values internally, and emits one `step_valid` per iteration. The upstream scheduler controls it with a start/done handshake. The downstream consumer can hold it with `stall`.

## Interface
- `WIDTH`, default 16: width of the dimension inputs, index mirrors and the attached counters.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  start request; sampled only in IDLE.
- `rows`  in  WIDTH  outer trip count; latched on an accepted start.
- `cols`  in  WIDTH  inner trip count; latched on an accepted start.
- `stall`  in  1  consumer back-pressure; freezes iteration while high.
- `row_load`  out  2  load code to the outer counter.
- `col_load`  out  2  load code to the inner counter.
- `row_idx`  out  WIDTH  mirror of the outer counter value.
- `col_idx`  out  WIDTH  mirror of the inner counter value.
- `step_valid`  out  1  the current (`row_idx`, `col_idx`) is being issued this cycle.
- `last`  out  1  qualifies the final `step_valid`.
- `busy`  out  1  traversal in progress (CLEAR or RUN).
- `done`  out  1  one-cycle completion pulse.

## Operation
- Load codes: 2'd0 = hold, 2'd1 = increment, 2'd2 = clear. 2'd3 is never driven.
- States: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - `start`=1 latches `rows`/`cols`.
  - If either latched value is 0, go to DONE. No steps are issued and no clear is driven.
  - Otherwise go to CLEAR.
  - `start` in any other state is ignored and not queued.
- CLEAR (one cycle):
  - `row_load` = `col_load` = 2'd2.
  - Mirrors clear at the same edge.
  - Go to RUN.
- RUN with `stall`=0:
  - `step_valid`=1.
  - If `col_idx` ≠ cols−1: `col_load`=1.
  - Else if `row_idx` ≠ rows−1: `col_load`=2 and `row_load`=1.
  - Else: `last`=1, `col_load`=2, `row_load`=2, and go to DONE.
- RUN with `stall`=1: `step_valid`=0, `last`=0, both load codes 0. Counters and mirrors hold.
- DONE (one cycle): `done`=1, `busy`=0, then go to IDLE.
- `row_load`, `col_load`, `step_valid` and `last` are combinational from state, mirrors and `stall`. Mirrors and state are registered.
- Mirrors update with exactly the load code they drive, so `row_idx`/`col_idx` always equal the attached counter outputs.
- Comparisons are against latched dims minus 1 at WIDTH bits. The zero-dimension case never reaches RUN, so no underflow occurs.
- Maximum dims are 2^WIDTH−1 per axis. Indices never wrap.

## Timing
- Reset: state IDLE. All outputs 0, including load codes, mirrors, `busy` and `done`.
- Reset is asynchronous. Asserting it mid-RUN aborts immediately with no `done`. The attached counters keep stale values until the next CLEAR.
- Start accepted at edge T (nonzero dims):
  - CLEAR during cycle T+1; `busy`=1 from T+1.
  - First `step_valid` in cycle T+2.
  - Without stalls, the last step falls in cycle T+1+R·C and `done` pulses in cycle T+2+R·C.
- Each stall cycle delays all later events by one cycle.
- Zero-dimension start at T: `done` in cycle T+1, `busy` stays 0.
- A `start` in the DONE cycle is ignored. The earliest accepted restart is the following IDLE cycle.

## Configuration
- `LOOP_SEQ_ABORT_EN`
  - Defined: adds input port `abort` (1 bit). `abort`=1 in CLEAR or RUN has priority over `stall`: that cycle `step_valid`=0, `last`=0, both load codes 2'd2, mirrors clear, and the next state is DONE. `done` pulses normally. `abort` is ignored in IDLE and DONE.
  - Undefined: no `abort` port exists and traversal always runs to completion.

## Test plan
- rows=2, cols=3, no stall → `step_valid` 6 cycles with indices (0,0)(0,1)(0,2)(1,0)(1,1)(1,2), `last` on (1,2), `done` 8 cycles after start; the attached counters read 0 afterwards.
- rows=2, cols=2, `stall` high on the 2nd and 3rd RUN cycles → load codes 0 and indices frozen at (0,1) during the stall, 4 valid steps total, `done` delayed by 2 cycles.
- rows=0, cols=5 → no `step_valid` and no load codes; `done` the next cycle; `busy` never asserted.
- Start with rows=1, cols=4, then pulse start again mid-RUN with rows=9 → exactly 4 steps; the second start is ignored.
- Assert `rst` at step (0,2) of a 3×3 run → all outputs 0 asynchronously with no `done`; a fresh start afterwards begins at (0,0) after CLEAR.
- With `LOOP_SEQ_ABORT_EN`, abort at step (1,0) of a 3×3 run → no `step_valid` that cycle, load codes 2/2, `done` next cycle, mirrors 0.
